// File: rtl/inst_dispatch_pkg.sv
// Types and constants shared by the dispatcher, the array controllers and the instruction loader.
package inst_dispatch_pkg;

    typedef enum logic {
        DRUN,
        DFENCE
    } DispFSM;

    typedef enum logic [1:0] {
        ITM     = 2'd0,
        ITV     = 2'd1,
        ITE     = 2'd2,
        ITFENCE = 2'd3
    } InstType;

    localparam int DispPayloadW = 128;

endpackage

// File: rtl/inst_dispatch_port.sv
// One controller port: registered valid/payload toward the controller
// plus the count of instructions issued but not yet reported done.
module disp_port #(
    parameter int PAYLOAD_W = 128,
    parameter int MAX_OUT   = 4,
    parameter int CNT_W     = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 accept,
    input  logic [PAYLOAD_W-1:0] payloadIn,
    input  logic                 ready,
    input  logic                 done,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] payload,
    output logic [CNT_W-1:0]     count,
    output logic                 canAccept,
    output logic                 errPulse
);

    assign canAccept = (!valid || ready) && (count < CNT_W'(MAX_OUT));
    // An accept and a done in the same cycle cancel out, so no underflow is possible then.
    assign errPulse  = done && !accept && (count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            payload <= '0;
            count   <= '0;
        end else begin
            if (accept) begin
                valid   <= 1'b1;
                payload <= payloadIn;
            end else if (ready) begin
                valid <= 1'b0;
            end

            if (accept && !done) begin
                count <= count + CNT_W'(1);
            end else if (done && !accept && (count != '0)) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_dispatch.sv
// In-order dispatcher routing M/V/E instructions to three controllers, with FENCE draining.
// Optional build macro: DISPATCH_PERF_EN adds stall_cnt and fence_cnt performance counters.
module inst_dispatch
    import inst_dispatch_pkg::*;
#(
    parameter int PAYLOAD_W = DispPayloadW,
    parameter int MAX_OUT   = 4,
    parameter int CNT_W     = $clog2(MAX_OUT + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_type,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [PAYLOAD_W-1:0] m_payload,
    input  logic                 m_done,
    output logic                 v_valid,
    input  logic                 v_ready,
    output logic [PAYLOAD_W-1:0] v_payload,
    input  logic                 v_done,
    output logic                 e_valid,
    input  logic                 e_ready,
    output logic [PAYLOAD_W-1:0] e_payload,
    input  logic                 e_done,
    output logic                 busy,
    output logic                 err
`ifdef DISPATCH_PERF_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          fence_cnt
`endif
);

    DispFSM           state;
    DispFSM           stateNext;
    InstType          inType;
    logic             accM, accV, accE;
    logic             canM, canV, canE;
    logic             errM, errV, errE;
    logic [CNT_W-1:0] cntM, cntV, cntE;
    logic             drained;

    assign inType  = InstType'(in_type);
    assign drained = (cntM == '0) && (cntV == '0) && (cntE == '0)
                     && !m_valid && !v_valid && !e_valid;

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        accM      = 1'b0;
        accV      = 1'b0;
        accE      = 1'b0;
        case (state)
            DRUN: begin
                case (inType)
                    ITM:     in_ready = canM;
                    ITV:     in_ready = canV;
                    ITE:     in_ready = canE;
                    default: in_ready = 1'b1;
                endcase
                if (in_valid && in_ready) begin
                    case (inType)
                        ITM:     accM = 1'b1;
                        ITV:     accV = 1'b1;
                        ITE:     accE = 1'b1;
                        default: stateNext = DFENCE;
                    endcase
                end
            end
            default: begin
                if (drained) begin
                    stateNext = DRUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DRUN;
            err   <= 1'b0;
        end else begin
            state <= stateNext;
            err   <= err | errM | errV | errE;
        end
    end

    assign busy = (cntM != '0) || (cntV != '0) || (cntE != '0)
                  || m_valid || v_valid || e_valid || (state == DFENCE);

`ifdef DISPATCH_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            fence_cnt <= '0;
        end else begin
            if ((state == DRUN) && in_valid && !in_ready) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (state == DFENCE) begin
                fence_cnt <= fence_cnt + 32'd1;
            end
        end
    end
`endif

    disp_port #(.PAYLOAD_W(PAYLOAD_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) uPortM (
        .clk(clk), .rst(rst), .accept(accM), .payloadIn(in_payload),
        .ready(m_ready), .done(m_done), .valid(m_valid), .payload(m_payload),
        .count(cntM), .canAccept(canM), .errPulse(errM)
    );

    disp_port #(.PAYLOAD_W(PAYLOAD_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) uPortV (
        .clk(clk), .rst(rst), .accept(accV), .payloadIn(in_payload),
        .ready(v_ready), .done(v_done), .valid(v_valid), .payload(v_payload),
        .count(cntV), .canAccept(canV), .errPulse(errV)
    );

    disp_port #(.PAYLOAD_W(PAYLOAD_W), .MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) uPortE (
        .clk(clk), .rst(rst), .accept(accE), .payloadIn(in_payload),
        .ready(e_ready), .done(e_done), .valid(e_valid), .payload(e_payload),
        .count(cntE), .canAccept(canE), .errPulse(errE)
    );

endmodule

// File: tb/tb_inst_dispatch.sv
// Directed bench for inst_dispatch: scoreboard of issued payloads per controller port.
module tb_inst_dispatch;
    import inst_dispatch_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_type;
    logic [127:0] in_payload;
    logic         m_valid, v_valid, e_valid;
    logic         m_ready, v_ready, e_ready;
    logic [127:0] m_payload, v_payload, e_payload;
    logic         m_done, v_done, e_done;
    logic         busy, err;

    int nTests = 0;
    int nFail  = 0;
    logic [127:0] qM[$];
    logic [127:0] qV[$];
    logic [127:0] qE[$];

    always #5 clk = ~clk;

    inst_dispatch dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_payload(in_payload),
        .m_valid(m_valid), .m_ready(m_ready), .m_payload(m_payload), .m_done(m_done),
        .v_valid(v_valid), .v_ready(v_ready), .v_payload(v_payload), .v_done(v_done),
        .e_valid(e_valid), .e_ready(e_ready), .e_payload(e_payload), .e_done(e_done),
        .busy(busy), .err(err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive an instruction, check the combinational in_ready, and record the expected issue.
    task automatic send(input logic [1:0] t, input logic [127:0] p, input logic expReady);
        in_valid   = 1'b1;
        in_type    = t;
        in_payload = p;
        #1;
        chk("in_ready", in_ready, expReady);
        if (expReady) begin
            case (t)
                2'd0: qM.push_back(p);
                2'd1: qV.push_back(p);
                2'd2: qE.push_back(p);
                default: ;
            endcase
        end
    endtask

    // Scoreboard: each controller handshake must present the oldest outstanding payload.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid && m_ready) begin
                chk("m_underflow", 128'(qM.size() != 0), 128'd1);
                if (qM.size() != 0) chk("m_payload", m_payload, qM.pop_front());
            end
            if (v_valid && v_ready) begin
                chk("v_underflow", 128'(qV.size() != 0), 128'd1);
                if (qV.size() != 0) chk("v_payload", v_payload, qV.pop_front());
            end
            if (e_valid && e_ready) begin
                chk("e_underflow", 128'(qE.size() != 0), 128'd1);
                if (qE.size() != 0) chk("e_payload", e_payload, qE.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_type = 2'd0; in_payload = '0;
        m_ready = 1'b1; v_ready = 1'b1; e_ready = 1'b1;
        m_done = 1'b0; v_done = 1'b0; e_done = 1'b0;
        tick(); tick();
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_v_valid", v_valid, 1'b0);
        chk("rst_e_valid", e_valid, 1'b0);
        chk("rst_m_payload", m_payload, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // M, V, E each issued once
        send(2'd0, 128'h100, 1'b1); tick();
        chk("t1_m_valid", m_valid, 1'b1);
        chk("t1_cnt_m", 128'(dut.cntM), 128'd1);
        send(2'd1, 128'h200, 1'b1); tick();
        chk("t1_v_valid", v_valid, 1'b1);
        chk("t1_cnt_v", 128'(dut.cntV), 128'd1);
        send(2'd2, 128'h300, 1'b1); tick();
        in_valid = 1'b0;
        chk("t1_e_valid", e_valid, 1'b1);
        chk("t1_cnt_e", 128'(dut.cntE), 128'd1);
        chk("t1_busy", busy, 1'b1);
        m_done = 1'b1; v_done = 1'b1; e_done = 1'b1; tick();
        m_done = 1'b0; v_done = 1'b0; e_done = 1'b0;
        tick();
        chk("t1_drain_busy", busy, 1'b0);

        // Outstanding limit on M
        for (int i = 0; i < 4; i++) begin
            send(2'd0, 128'h1000 + 128'(i), 1'b1); tick();
        end
        send(2'd0, 128'h1004, 1'b0); tick();
        chk("t2_stall_again", in_ready, 1'b0);
        m_done = 1'b1; tick();
        m_done = 1'b0;
        send(2'd0, 128'h1004, 1'b1); tick();
        in_valid = 1'b0;
        chk("t2_cnt_m_max", 128'(dut.cntM), 128'd4);
        m_done = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        m_done = 1'b0;
        chk("t2_cnt_m_drained", 128'(dut.cntM), 128'd0);

        // Backpressure preserves order
        m_ready = 1'b0;
        send(2'd0, 128'hA1, 1'b1); tick();
        send(2'd0, 128'hA2, 1'b0); tick();
        chk("t3_hold_ready", in_ready, 1'b0);
        chk("t3_hold_payload", m_payload, 128'hA1);
        chk("t3_v_not_issued", v_valid, 1'b0);
        m_ready = 1'b1;
        send(2'd0, 128'hA2, 1'b1); tick();
        send(2'd1, 128'hB1, 1'b1); tick();
        in_valid = 1'b0;
        chk("t3_v_valid", v_valid, 1'b1);
        m_done = 1'b1; v_done = 1'b1; tick();
        v_done = 1'b0; tick();
        m_done = 1'b0;
        chk("t3_cnt_m", 128'(dut.cntM), 128'd0);

        // FENCE holds E until M drains
        send(2'd0, 128'hC1, 1'b1); tick();
        send(2'd3, 128'h0, 1'b1); tick();
        chk("t4_state_fence", 128'(dut.state), 128'(DFENCE));
        send(2'd2, 128'hE1, 1'b0); tick();
        send(2'd2, 128'hE1, 1'b0); tick();
        m_done = 1'b1; tick();
        m_done = 1'b0;
        send(2'd2, 128'hE1, 1'b0);
        chk("t4_still_fence", 128'(dut.state), 128'(DFENCE));
        tick();
        chk("t4_state_run", 128'(dut.state), 128'(DRUN));
        send(2'd2, 128'hE1, 1'b1); tick();
        in_valid = 1'b0;
        chk("t4_e_valid", e_valid, 1'b1);
        e_done = 1'b1; tick();
        e_done = 1'b0; tick();

        // FENCE with everything drained: two cycles
        send(2'd3, 128'h0, 1'b1); tick();
        send(2'd2, 128'hE2, 1'b0); tick();
        send(2'd2, 128'hE2, 1'b1); tick();
        in_valid = 1'b0;
        e_done = 1'b1; tick();
        e_done = 1'b0;

        // Accept and done together; done underflow sets sticky err
        send(2'd0, 128'hD1, 1'b1); tick();
        send(2'd0, 128'hD2, 1'b1); tick();
        send(2'd0, 128'hD3, 1'b1);
        m_done = 1'b1; tick();
        in_valid = 1'b0; m_done = 1'b0;
        chk("t5_cnt_m_same", 128'(dut.cntM), 128'd2);
        chk("t5_err_clear", err, 1'b0);
        v_done = 1'b1; tick();
        v_done = 1'b0;
        chk("t5_err_set", err, 1'b1);
        chk("t5_cnt_v_zero", 128'(dut.cntV), 128'd0);
        tick(); tick();
        chk("t5_err_sticky", err, 1'b1);
        m_done = 1'b1; tick(); tick();
        m_done = 1'b0;

        // Reset during pending FENCE with a held instruction
        m_ready = 1'b0;
        send(2'd0, 128'hF1, 1'b1); tick();
        send(2'd3, 128'h0, 1'b1); tick();
        in_valid = 1'b0;
        chk("t6_fence_pending", 128'(dut.state), 128'(DFENCE));
        rst = 1'b1; tick();
        qM.delete();
        chk("t6_m_valid", m_valid, 1'b0);
        chk("t6_m_payload", m_payload, '0);
        chk("t6_cnt_m", 128'(dut.cntM), 128'd0);
        chk("t6_err", err, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_state", 128'(dut.state), 128'(DRUN));
        rst = 1'b0; m_ready = 1'b1;
        #1;
        chk("t6_in_ready", in_ready, 1'b1);
        tick();

        chk("sb_m_empty", 128'(qM.size()), 128'd0);
        chk("sb_v_empty", 128'(qV.size()), 128'd0);
        chk("sb_e_empty", 128'(qE.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/inst_dispatch.md
# inst_dispatch

In-order instruction dispatcher that sits between the global instruction queue and the three array controllers (MPE, VPE, element). It takes a single tagged instruction stream, routes each instruction to the matching controller through a registered valid/ready port, and tracks how many instructions each controller has in flight. FENCE instructions hold issue until every controller has drained, which orders the M/V/E phases that the controllers' sync flags cannot order on their own.

## Interface
- PAYLOAD_W, 128: width of the instruction payload; holds a packed MInst, VInst or EInst, zero-extended.
- MAX_OUT, 4: maximum number of in-flight (issued, not done) instructions per controller; must be at least 1.
- CNT_W, $clog2(MAX_OUT+1): width of the outstanding counters (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  instruction accepted this cycle when high together with in_valid
- in_type  in  2  0=M, 1=V, 2=E, 3=FENCE
- in_payload  in  PAYLOAD_W  instruction body; ignored for FENCE
- m_valid / v_valid / e_valid  out  1  per-controller instruction valid
- m_ready / v_ready / e_ready  in  1  per-controller accept
- m_payload / v_payload / e_payload  out  PAYLOAD_W  registered payload
- m_done / v_done / e_done  in  1  one-cycle pulse: the controller finished one instruction
- busy  out  1  high when any counter is nonzero, any x_valid is high, or state is DFENCE
- err  out  1  sticky: a done pulse arrived while the matching counter was 0

## Operation
- FSM (DispFSM): DRUN and DFENCE. Reset state is DRUN.
- In DRUN, in_ready is combinational on in_type:
  - M, V, E: in_ready = (!x_valid || x_ready) && (cnt_x < MAX_OUT).
  - FENCE: in_ready = 1.
- In DFENCE, in_ready = 0.
- Accept of an M/V/E instruction: on the next edge x_valid=1 and x_payload=in_payload, and cnt_x increments.
- x_valid falls when x_ready is high and there is no accept into the same port that cycle. Back-to-back accepts keep x_valid high, with the payload replaced by the new instruction.
- The counter counts issues to the register, not controller handshakes. A held instruction already counts as outstanding.
- x_done decrements cnt_x.
  - Accept and done in the same cycle: cnt_x is unchanged.
  - Done with cnt_x == 0: the counter stays 0 and err is set.
- FENCE accept: go to DFENCE. Return to DRUN on the cycle after all three counters are 0 and all x_valid are low. Done pulses that arrive during DFENCE are counted normally.
- Routing is strictly in order: a blocked head instruction stalls all later instructions, including ones for idle controllers.
- Reset values: every x_valid = 0, every x_payload = 0, every counter = 0, err = 0, busy = 0, in_ready follows the DRUN rule. Reset mid-operation drops any held instructions without issuing them.

## Timing
- Latency from accept to x_valid is 1 cycle.
- Sustained throughput is 1 instruction/cycle when the target controller's x_ready stays high and its counter stays below MAX_OUT.
- FENCE overhead: when all units are already drained, it costs 2 cycles (accept cycle plus the DFENCE cycle).
- All outputs are registered except in_ready.

## Configuration
- DISPATCH_PERF_EN defined:
  - Adds 32-bit outputs stall_cnt (cycles with in_valid && !in_ready in DRUN) and fence_cnt (cycles spent in DFENCE).
  - Both counters reset to 0 and wrap at 2^32.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

## Structure
- Shared package holds the following, so the controllers and the instruction loader share them:
  - DispFSM enum {DRUN, DFENCE}
  - InstType enum {ITM, ITV, ITE, ITFENCE} (2 bits)
  - DispPayloadW constant
- One sub-module, disp_port: output register plus outstanding counter for one controller, instantiated three times. It takes an accept strobe and has done/ready inputs; it outputs valid, payload, count, a can_accept flag and an err pulse.

## Test plan
- Reset, then M, V, E issued with all ready=1 and no done pulses: each x_valid rises 1 cycle after its accept, each counter reads 1, busy=1.
- MAX_OUT=4, m_ready=1, no m_done: five M instructions; in_ready drops on the fifth. One m_done pulse makes it accepted the next cycle, and cnt_m stays 4.
- m_ready=0 with two M instructions queued: the second stalls with in_ready=0, m_payload holds the first value, and a following V instruction is not issued (order preserved).
- Issue M, then FENCE, then E: E stays blocked until m_done arrives, the FSM returns to DRUN the cycle after, and E is accepted on the cycle after that.
- Accept and m_done in the same cycle with cnt_m=2: cnt_m stays 2. A v_done with cnt_v=0 sets err=1, and err stays 1 until rst.
- rst asserted while a FENCE is pending and x_valid is high: the next cycle shows all outputs at their reset values and the state is DRUN.
